// File: rtl/cdb_arbiter.sv
// Purpose : round-robin arbiter sharing the single ROB completion (CDB) write port.
// Latency : 0 cycles by default (combinational); 1 cycle when CDB_REG_EN is defined.
// Backpr. : req_ready is withheld while the ROB is not ready (or the output stage is
//           full) and during flush; units hold their payload until req_ready.
//
// Optional feature macro: CDB_REG_EN (registered output stage). Undefined = combinational.
//
// Ports
//   clk, rst          clock and synchronous active-low reset
//   flush             ROB stop; kills any pending completion, rr_ptr restarts at 0
//   req_valid         per-unit completion request
//   req_tag_prf/rob   per-unit payload, unit i occupies slice i
//   req_ready         per-unit accept strobe (onehot or zero)
//   cdb_valid/tag_*   completion presented to the ROB
//   cdb_src           index of the unit that produced the presented completion
//   rob_ready         ROB can take a completion this cycle
module cdb_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int PRF_TAG_W = 4,
  parameter int ROB_TAG_W = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*PRF_TAG_W-1:0]   req_tag_prf,
  input  logic [NUM_REQ*ROB_TAG_W-1:0]   req_tag_rob,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           cdb_valid,
  output logic [PRF_TAG_W-1:0]           cdb_tag_prf,
  output logic [ROB_TAG_W-1:0]           cdb_tag_rob,
  output logic [$clog2(NUM_REQ)-1:0]     cdb_src,
  input  logic                           rob_ready
);

  localparam int SRC_W = $clog2(NUM_REQ);
  localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(NUM_REQ - 1);

  // Round-robin pointer: the unit scanned first in the current cycle.
  logic [SRC_W-1:0]     rr_ptr_q;
  logic [SRC_W-1:0]     rr_ptr_d;

  logic [NUM_REQ-1:0]   grant;
  logic [SRC_W-1:0]     grant_idx;
  logic                 grant_vld;
  logic [PRF_TAG_W-1:0] win_prf;
  logic [ROB_TAG_W-1:0] win_rob;
  logic [SRC_W-1:0]     ptr_after_grant;
  logic                 accept;
  int                   scan_idx;

  // Scan rr_ptr, rr_ptr+1, ... modulo NUM_REQ and take the first requester.
  // The wrap is done explicitly so non-power-of-2 NUM_REQ never lands on an
  // index that does not exist.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    scan_idx  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = int'(rr_ptr_q) + k;
      if (scan_idx >= NUM_REQ) begin
        scan_idx = scan_idx - NUM_REQ;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grant_vld && (i == scan_idx) && req_valid[i]) begin
          grant[i]  = 1'b1;
          grant_idx = SRC_W'(i);
          grant_vld = 1'b1;
        end
      end
    end
  end

  // Payload of the winning unit (zero when nobody requests).
  always_comb begin
    win_prf = '0;
    win_rob = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win_prf = req_tag_prf[i*PRF_TAG_W +: PRF_TAG_W];
        win_rob = req_tag_rob[i*ROB_TAG_W +: ROB_TAG_W];
      end
    end
  end

  // Pointer moves to the unit after the winner, wrapping at NUM_REQ-1.
  always_comb begin
    ptr_after_grant = grant_idx + SRC_W'(1);
    if (grant_idx == LAST_IDX) begin
      ptr_after_grant = '0;
    end
  end

`ifdef CDB_REG_EN
  // Registered output stage: a new winner may load whenever the stage is
  // empty or is being drained by the ROB in this same cycle.
  logic                 cdb_valid_q;
  logic                 cdb_valid_d;
  logic [PRF_TAG_W-1:0] cdb_tag_prf_q;
  logic [PRF_TAG_W-1:0] cdb_tag_prf_d;
  logic [ROB_TAG_W-1:0] cdb_tag_rob_q;
  logic [ROB_TAG_W-1:0] cdb_tag_rob_d;
  logic [SRC_W-1:0]     cdb_src_q;
  logic [SRC_W-1:0]     cdb_src_d;

  assign accept = rst && !flush && (!cdb_valid_q || rob_ready) && grant_vld;

  always_comb begin
    cdb_valid_d   = cdb_valid_q;
    cdb_tag_prf_d = cdb_tag_prf_q;
    cdb_tag_rob_d = cdb_tag_rob_q;
    cdb_src_d     = cdb_src_q;
    if (accept) begin
      cdb_valid_d   = 1'b1;
      cdb_tag_prf_d = win_prf;
      cdb_tag_rob_d = win_rob;
      cdb_src_d     = grant_idx;
    end else if (rob_ready || flush) begin
      // Drained by the ROB, or discarded by flush even if the ROB is stalled.
      cdb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cdb_valid_q   <= 1'b0;
      cdb_tag_prf_q <= '0;
      cdb_tag_rob_q <= '0;
      cdb_src_q     <= '0;
    end else begin
      cdb_valid_q   <= cdb_valid_d;
      cdb_tag_prf_q <= cdb_tag_prf_d;
      cdb_tag_rob_q <= cdb_tag_rob_d;
      cdb_src_q     <= cdb_src_d;
    end
  end

  // Masked by rst so the port reads 0 from the very first reset cycle.
  assign cdb_valid   = cdb_valid_q && rst;
  assign cdb_tag_prf = cdb_tag_prf_q;
  assign cdb_tag_rob = cdb_tag_rob_q;
  assign cdb_src     = cdb_src_q;
`else
  // Combinational path: the winner is presented directly; the unit is only
  // released when the ROB takes it in the same cycle.
  assign accept      = rst && !flush && rob_ready && grant_vld;
  assign cdb_valid   = grant_vld && !flush && rst;
  assign cdb_tag_prf = win_prf;
  assign cdb_tag_rob = win_rob;
  assign cdb_src     = grant_idx;
`endif

  assign req_ready = accept ? grant : '0;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (flush) begin
      rr_ptr_d = '0;
    end else if (accept) begin
      rr_ptr_d = ptr_after_grant;
    end
  end

  // Reset takes priority over flush; both leave the pointer at 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: one 2-requester and one 3-requester instance, directed
// scenarios plus randomized traffic checked against a queue-free behavioural model
// (round-robin scan with modulo arithmetic, one-slot output buffer when registered).
module tb_cdb_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, flush, rob_ready;
  logic [1:0] v2;   logic [7:0]  p2, r2;
  logic [1:0] rdy2; logic cv2;  logic [3:0] ctp2, ctr2; logic [0:0] src2;
  logic [2:0] v3;   logic [11:0] p3, r3;
  logic [2:0] rdy3; logic cv3;  logic [3:0] ctp3, ctr3; logic [1:0] src3;

  int vectors = 0;
  int miscompares = 0;

  cdb_arbiter #(.NUM_REQ(2), .PRF_TAG_W(4), .ROB_TAG_W(4)) dut2 (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(v2), .req_tag_prf(p2),
    .req_tag_rob(r2), .req_ready(rdy2), .cdb_valid(cv2), .cdb_tag_prf(ctp2),
    .cdb_tag_rob(ctr2), .cdb_src(src2), .rob_ready(rob_ready));

  cdb_arbiter #(.NUM_REQ(3), .PRF_TAG_W(4), .ROB_TAG_W(4)) dut3 (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(v3), .req_tag_prf(p3),
    .req_tag_rob(r3), .req_ready(rdy3), .cdb_valid(cv3), .cdb_tag_prf(ctp3),
    .cdb_tag_rob(ctr3), .cdb_src(src3), .rob_ready(rob_ready));

  typedef struct {
    int         n;
    int         w;      // winning unit, -1 if none
    logic       acc;
    logic [7:0] rdy;
    logic       vld;
    logic [3:0] prf, rob;
    int         src;
    logic [3:0] wprf, wrob;
  } exp_t;

  // Model state per instance: pointer plus (registered mode) a one-entry output slot.
  int         m_ptr [2];
  logic       m_v   [2];
  logic [3:0] m_prf [2];
  logic [3:0] m_rob [2];
  int         m_src [2];
  exp_t       last_e0, last_e1;

  function automatic int pick(input int n, input int ptr, input logic [7:0] v);
    for (int k = 0; k < n; k++) begin
      int i;
      i = (ptr + k) % n;
      if (v[i[2:0]]) return i;
    end
    return -1;
  endfunction

  function automatic exp_t model_out(input int d);
    exp_t e;
    logic [7:0] v;
    logic [31:0] p, r;
    if (d == 0) begin
      e.n = 2; v = {6'd0, v2}; p = {24'd0, p2}; r = {24'd0, r2};
    end else begin
      e.n = 3; v = {5'd0, v3}; p = {20'd0, p3}; r = {20'd0, r3};
    end
    e.w = pick(e.n, m_ptr[d], v);
    e.wprf = 4'd0;
    e.wrob = 4'd0;
    if (e.w >= 0) begin
      e.wprf = 4'(p >> (4 * e.w));
      e.wrob = 4'(r >> (4 * e.w));
    end
`ifdef CDB_REG_EN
    e.acc = rst && !flush && (!m_v[d] || rob_ready) && (e.w >= 0);
    e.vld = rst && m_v[d];
    e.prf = m_prf[d];
    e.rob = m_rob[d];
    e.src = m_src[d];
`else
    e.acc = rst && !flush && rob_ready && (e.w >= 0);
    e.vld = rst && !flush && (e.w >= 0);
    e.prf = e.wprf;
    e.rob = e.wrob;
    e.src = (e.w >= 0) ? e.w : 0;
`endif
    e.rdy = e.acc ? (8'd1 << e.w) : 8'd0;
    return e;
  endfunction

  function automatic void commit(input int d, input exp_t e);
    if (!rst) begin
      m_ptr[d] = 0; m_v[d] = 1'b0; m_prf[d] = 4'd0; m_rob[d] = 4'd0; m_src[d] = 0;
    end else if (flush) begin
      m_ptr[d] = 0; m_v[d] = 1'b0;
    end else if (e.acc) begin
      m_ptr[d] = (e.w + 1) % e.n;
      m_v[d]   = 1'b1;
      m_prf[d] = e.wprf;
      m_rob[d] = e.wrob;
      m_src[d] = e.w;
    end else if (rob_ready) begin
      m_v[d] = 1'b0;
    end
  endfunction

  // Evaluate the model on the settled inputs, take the clock edge, update the model,
  // and return 1 time unit after the edge so new inputs can be driven.
  task automatic advance();
    last_e0 = model_out(0);
    last_e1 = model_out(1);
    @(posedge clk);
    commit(0, last_e0);
    commit(1, last_e1);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; rob_ready = 1'b1;
    v2 = 2'b11; p2 = 8'h21; r2 = 8'hBA;
    v3 = 3'b111; p3 = 12'h321; r3 = 12'hCBA;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++;
      if (cv2 !== 1'b0 || rdy2 !== 2'b00) begin
        miscompares++;
        $display("FAIL reset_n2 cyc%0d: cdb_valid=%b req_ready=%b, need 0/00", k, cv2, rdy2);
      end
      vectors++;
      if (cv3 !== 1'b0 || rdy3 !== 3'b000) begin
        miscompares++;
        $display("FAIL reset_n3 cyc%0d: cdb_valid=%b req_ready=%b, need 0/000", k, cv3, rdy3);
      end
      advance();
    end
    rst = 1'b1;
    v3 = 3'b000;
    @(negedge clk);
    vectors++;
    if (rdy2 !== 2'b01) begin
      miscompares++;
      $display("FAIL reset_first_grant: req_ready=%b, need 01", rdy2);
    end
    advance();
  endtask

  task automatic test_contention();
    exp_t e;
    logic [1:0] want;
    // Flush with no requests restarts the pointer at 0 and empties any output stage.
    v2 = 2'b00; flush = 1'b1;
    advance();
    flush = 1'b0; v2 = 2'b11; p2 = 8'h21; r2 = 8'hBA; rob_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      e = model_out(0);
      want = 2'b01 << (k % 2);
      vectors++;
      if (rdy2 !== want) begin
        miscompares++;
        $display("FAIL contention_seq acc%0d: req_ready=%b, need %b", k, rdy2, want);
      end
      vectors++;
      if (cv2 !== e.vld || (e.vld && (ctp2 !== e.prf || ctr2 !== e.rob || int'(src2) != e.src))) begin
        miscompares++;
        $display("FAIL contention_cdb acc%0d: v=%b prf=%h rob=%h src=%0d, need v=%b prf=%h rob=%h src=%0d",
                 k, cv2, ctp2, ctr2, src2, e.vld, e.prf, e.rob, e.src);
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int xfers;
    v2 = 2'b00; rob_ready = 1'b1;
    advance();
    v2 = 2'b10; p2 = 8'h50; r2 = 8'h90; rob_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      e = model_out(0);
      vectors++;
      if (rdy2 !== e.rdy[1:0] || cv2 !== e.vld) begin
        miscompares++;
        $display("FAIL stall_model cyc%0d: req_ready=%b v=%b, need %b/%b", k, rdy2, cv2, e.rdy[1:0], e.vld);
      end
      if (k > 0) begin
        vectors++;
        if (rdy2 !== 2'b00 || cv2 !== 1'b1 || ctp2 !== 4'd5 || ctr2 !== 4'd9 || src2 !== 1'b1) begin
          miscompares++;
          $display("FAIL stall_hold cyc%0d: rdy=%b v=%b prf=%h rob=%h src=%b, need 00/1/5/9/1",
                   k, rdy2, cv2, ctp2, ctr2, src2);
        end
      end
      advance();
`ifdef CDB_REG_EN
      if (k == 0) v2 = 2'b00;   // unit released; its completion now sits in the output stage
`endif
    end
    rob_ready = 1'b1;
    xfers = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (cv2 && rob_ready) begin
        xfers++;
        vectors++;
        if (ctp2 !== 4'd5 || ctr2 !== 4'd9) begin
          miscompares++;
          $display("FAIL stall_release_tags: prf=%h rob=%h, need 5/9", ctp2, ctr2);
        end
      end
      advance();
      v2 = 2'b00;
    end
    vectors++;
    if (xfers != 1) begin
      miscompares++;
      $display("FAIL stall_release_count: %0d transfers, need 1", xfers);
    end
  endtask

  task automatic test_flush();
    exp_t e;
    v2 = 2'b11; p2 = 8'h43; r2 = 8'hED; rob_ready = 1'b1;
    advance();
    advance();
    flush = 1'b1;
    @(negedge clk);
    e = model_out(0);
    vectors++;
    if (rdy2 !== 2'b00 || cv2 !== e.vld) begin
      miscompares++;
      $display("FAIL flush_cycle: req_ready=%b v=%b, need 00/%b", rdy2, cv2, e.vld);
    end
    advance();
    flush = 1'b0;
    @(negedge clk);
    vectors++;
    if (rdy2 !== 2'b01) begin
      miscompares++;
      $display("FAIL flush_next_grant: req_ready=%b, need 01", rdy2);
    end
`ifdef CDB_REG_EN
    vectors++;
    if (cv2 !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_killed: cdb_valid=%b, need 0", cv2);
    end
`endif
    advance();
    v2 = 2'b00;
    advance();
  endtask

  task automatic test_single();
    logic [3:0] seen [$];
    int bad_src;
    v2 = 2'b00; rob_ready = 1'b1; bad_src = 0;
    advance();
    for (int t = 1; t <= 5; t++) begin
      if (t <= 3) begin
        v2 = 2'b10; p2 = 8'h70; r2 = {4'(t), 4'h0};
      end else begin
        v2 = 2'b00;
      end
      @(negedge clk);
      if (t <= 3) begin
        vectors++;
        if (rdy2 !== 2'b10) begin
          miscompares++;
          $display("FAIL single_grant %0d: req_ready=%b, need 10", t, rdy2);
        end
      end
      if (cv2) begin
        seen.push_back(ctr2);
        if (src2 !== 1'b1) bad_src++;
      end
      advance();
    end
    vectors++;
    if (seen.size() != 3 || seen[0] !== 4'd1 || seen[1] !== 4'd2 || seen[2] !== 4'd3 || bad_src != 0) begin
      miscompares++;
      $display("FAIL single_stream: %0d completions (first rob %h), bad src %0d, need rob 1,2,3 from src 1",
               seen.size(), (seen.size() > 0) ? seen[0] : 4'hx, bad_src);
    end
  endtask

  task automatic test_wrap3();
    exp_t e;
    logic [2:0] want;
    v2 = 2'b00; v3 = 3'b000; flush = 1'b1;
    advance();
    flush = 1'b0; rob_ready = 1'b1;
    v3 = 3'b111; p3 = 12'h321; r3 = 12'hCBA;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      e = model_out(1);
      want = 3'b001 << (k % 3);
      vectors++;
      if (rdy3 !== want) begin
        miscompares++;
        $display("FAIL wrap3_seq acc%0d: req_ready=%b, need %b", k, rdy3, want);
      end
      vectors++;
      if (cv3 !== e.vld || (e.vld && (ctp3 !== e.prf || ctr3 !== e.rob || int'(src3) != e.src))) begin
        miscompares++;
        $display("FAIL wrap3_cdb acc%0d: v=%b prf=%h rob=%h src=%0d, need v=%b prf=%h rob=%h src=%0d",
                 k, cv3, ctp3, ctr3, src3, e.vld, e.prf, e.rob, e.src);
      end
      advance();
    end
    v3 = 3'b000;
    advance();
  endtask

  task automatic test_random();
    exp_t e0, e1;
    logic [3:0] u2p [2], u2r [2], u3p [3], u3r [3];
    for (int i = 0; i < 3; i++) begin
      u3p[i] = 4'd0; u3r[i] = 4'd0;
      if (i < 2) begin u2p[i] = 4'd0; u2r[i] = 4'd0; end
    end
    v2 = 2'b00; v3 = 3'b000;
    for (int c = 0; c < 400; c++) begin
      // Units only change payload after their current completion was accepted.
      for (int i = 0; i < 2; i++) begin
        if (!v2[i] || last_e0.rdy[i]) begin
          v2[i]  = ($urandom_range(0, 9) < 6);
          u2p[i] = 4'($urandom);
          u2r[i] = 4'($urandom);
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (!v3[i] || last_e1.rdy[i]) begin
          v3[i]  = ($urandom_range(0, 9) < 6);
          u3p[i] = 4'($urandom);
          u3r[i] = 4'($urandom);
        end
      end
      p2 = {u2p[1], u2p[0]}; r2 = {u2r[1], u2r[0]};
      p3 = {u3p[2], u3p[1], u3p[0]}; r3 = {u3r[2], u3r[1], u3r[0]};
      flush     = ($urandom_range(0, 19) == 0);
      rob_ready = ($urandom_range(0, 9) < 7);
      rst       = ($urandom_range(0, 99) != 0);
      @(negedge clk);
      e0 = model_out(0);
      e1 = model_out(1);
      vectors++;
      if (rdy2 !== e0.rdy[1:0] || cv2 !== e0.vld) begin
        miscompares++;
        $display("FAIL rand_n2_hs c%0d: req_ready=%b v=%b, need %b/%b", c, rdy2, cv2, e0.rdy[1:0], e0.vld);
      end
      vectors++;
      if (e0.vld && (ctp2 !== e0.prf || ctr2 !== e0.rob || int'(src2) != e0.src)) begin
        miscompares++;
        $display("FAIL rand_n2_data c%0d: prf=%h rob=%h src=%0d, need %h/%h/%0d", c, ctp2, ctr2, src2, e0.prf, e0.rob, e0.src);
      end
      vectors++;
      if (rdy3 !== e1.rdy[2:0] || cv3 !== e1.vld) begin
        miscompares++;
        $display("FAIL rand_n3_hs c%0d: req_ready=%b v=%b, need %b/%b", c, rdy3, cv3, e1.rdy[2:0], e1.vld);
      end
      vectors++;
      if (e1.vld && (ctp3 !== e1.prf || ctr3 !== e1.rob || int'(src3) != e1.src)) begin
        miscompares++;
        $display("FAIL rand_n3_data c%0d: prf=%h rob=%h src=%0d, need %h/%h/%0d", c, ctp3, ctr3, src3, e1.prf, e1.rob, e1.src);
      end
      advance();
    end
    rst = 1'b1; flush = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_ptr[d] = 0; m_v[d] = 1'b0; m_prf[d] = 4'd0; m_rob[d] = 4'd0; m_src[d] = 0;
    end
    last_e0 = model_out(0);
    last_e1 = model_out(1);
    test_reset();
    test_contention();
    test_backpressure();
    test_flush();
    test_single();
    test_wrap3();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
